mem_ctrl: RTL

//  Owns the single byte-wide RAM port; shares it between instruction fetch (IF) and LSqueue (LS).

---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_ctrl_if.sv | 41 ++++
 rtl/mem_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial RAM port arbiter.
// Access sizes, FSM state codes and the size-to-last-byte-index helper.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LS_RD = 2'd1,
    ST_LS_WR = 2'd2,
    ST_IF_RD = 2'd3
  } state_t;

  // Index of the final byte cycle for an access of the given size (N-1).
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: last_byte = 2'd0;
      MEM_SIZE_H: last_byte = 2'd1;
      default:    last_byte = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between IF, LSqueue, the byte-wide RAM and mem_ctrl.
// slave is the controller's view, master the clients'/RAM's view.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              in_clear_all_reset;
  logic              in_if_ena;
  logic [ADDR_W-1:0] in_if_addr;
  logic              out_if_ready;
  logic [DATA_W-1:0] out_if_data;
  logic              in_ls_ena;
  logic              in_ls_iswrite;
  logic [1:0]        in_ls_size;
  logic [ADDR_W-1:0] in_ls_addr;
  logic [DATA_W-1:0] in_ls_data;
  logic              out_ls_ready;
  logic [DATA_W-1:0] out_ls_data;
  logic [7:0]        in_mem_din;
  logic [ADDR_W-1:0] out_mem_a;
  logic [7:0]        out_mem_dout;
  logic              out_mem_wr;

  modport slave (
    input  in_clear_all_reset, in_if_ena, in_if_addr,
    input  in_ls_ena, in_ls_iswrite, in_ls_size, in_ls_addr, in_ls_data,
    input  in_mem_din,
    output out_if_ready, out_if_data, out_ls_ready, out_ls_data,
    output out_mem_a, out_mem_dout, out_mem_wr
  );

  modport master (
    output in_clear_all_reset, in_if_ena, in_if_addr,
    output in_ls_ena, in_ls_iswrite, in_ls_size, in_ls_addr, in_ls_data,
    output in_mem_din,
    input  out_if_ready, out_if_data, out_ls_ready, out_ls_data,
    input  out_mem_a, out_mem_dout, out_mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and LSqueue; LS has priority.
// Latency N edges after grant (N=1/2/4 bytes); one idle cycle between ops; LS pulses queue in a 1-deep latch.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  state_t            state;
  logic [1:0]        k;
  logic [1:0]        last;
  logic [1:0]        k_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] next_a;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] rd_word;

  logic              lat_vld;
  logic              lat_wr;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;

  logic              grant_ls;
  logic              grant_if;
  logic              g_wr;
  logic [1:0]        g_size;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  // A request arriving while IDLE with an empty latch is granted straight from the inputs.
  always_comb begin
    grant_ls = (state == ST_IDLE) && (lat_vld || bus.in_ls_ena);
    grant_if = (state == ST_IDLE) && !grant_ls && bus.in_if_ena && !bus.in_clear_all_reset;
    g_wr     = lat_vld ? lat_wr   : bus.in_ls_iswrite;
    g_size   = lat_vld ? lat_size : bus.in_ls_size;
    g_addr   = lat_vld ? lat_addr : bus.in_ls_addr;
    g_data   = lat_vld ? lat_data : bus.in_ls_data;
    k_nxt    = k + 2'd1;
    next_a   = base + ADDR_W'(k_nxt);
    rd_word  = rbuf;
    rd_word[{k, 3'b000} +: 8] = bus.in_mem_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      k                <= '0;
      last             <= '0;
      base             <= '0;
      wdat             <= '0;
      rbuf             <= '0;
      lat_vld          <= 1'b0;
      lat_wr           <= 1'b0;
      lat_size         <= '0;
      lat_addr         <= '0;
      lat_data         <= '0;
      bus.out_if_ready <= 1'b0;
      bus.out_if_data  <= '0;
      bus.out_ls_ready <= 1'b0;
      bus.out_ls_data  <= '0;
      bus.out_mem_a    <= '0;
      bus.out_mem_dout <= '0;
      bus.out_mem_wr   <= 1'b0;
    end else begin
      bus.out_if_ready <= 1'b0;
      bus.out_ls_ready <= 1'b0;

      // Requests arriving while busy wait here; a second one before grant is dropped.
      if (bus.in_ls_ena && !lat_vld && (state != ST_IDLE)) begin
        lat_vld  <= 1'b1;
        lat_wr   <= bus.in_ls_iswrite;
        lat_size <= bus.in_ls_size;
        lat_addr <= bus.in_ls_addr;
        lat_data <= bus.in_ls_data;
      end

      case (state)
        ST_IDLE: begin
          if (grant_ls) begin
            state            <= g_wr ? ST_LS_WR : ST_LS_RD;
            lat_vld          <= 1'b0;
            base             <= g_addr;
            wdat             <= g_data;
            last             <= last_byte(g_size);
            k                <= '0;
            rbuf             <= '0;
            bus.out_mem_a    <= g_addr;
            bus.out_mem_wr   <= g_wr;
            bus.out_mem_dout <= g_wr ? g_data[7:0] : 8'h00;
          end else if (grant_if) begin
            state            <= ST_IF_RD;
            base             <= bus.in_if_addr;
            last             <= 2'd3;
            k                <= '0;
            rbuf             <= '0;
            bus.out_mem_a    <= bus.in_if_addr;
            bus.out_mem_wr   <= 1'b0;
            bus.out_mem_dout <= 8'h00;
          end else begin
            bus.out_mem_a    <= '0;
            bus.out_mem_wr   <= 1'b0;
            bus.out_mem_dout <= 8'h00;
          end
        end

        ST_LS_WR: begin
          if (k == last) begin
            state            <= ST_IDLE;
            bus.out_mem_a    <= '0;
            bus.out_mem_wr   <= 1'b0;
            bus.out_mem_dout <= 8'h00;
            bus.out_ls_ready <= 1'b1;
            bus.out_ls_data  <= '0;
          end else begin
            k                <= k_nxt;
            bus.out_mem_a    <= next_a;
            bus.out_mem_dout <= wdat[{k_nxt, 3'b000} +: 8];
          end
        end

        ST_LS_RD, ST_IF_RD: begin
          // Flush kills fetch work only, including a fetch on its final edge.
          if ((state == ST_IF_RD) && bus.in_clear_all_reset) begin
            state         <= ST_IDLE;
            bus.out_mem_a <= '0;
          end else if (k == last) begin
            state         <= ST_IDLE;
            rbuf          <= rd_word;
            bus.out_mem_a <= '0;
            if (state == ST_IF_RD) begin
              bus.out_if_ready <= 1'b1;
              bus.out_if_data  <= rd_word;
            end else begin
              bus.out_ls_ready <= 1'b1;
              bus.out_ls_data  <= rd_word;
            end
          end else begin
            k             <= k_nxt;
            rbuf          <= rd_word;
            bus.out_mem_a <= next_a;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
